// File: rtl/tonegen_pkg.sv
// tonegen_pkg: frame geometry, loader states and register map shared with the signal generator
package tonegen_pkg;
  localparam int FRAME_BITS = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 5;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [ADDR_W-1:0] REG_PERIOD    = 3'b000;
  localparam logic [ADDR_W-1:0] REG_VOL_A     = 3'b010;
  localparam logic [ADDR_W-1:0] REG_VOL_NOISE = 3'b100;
  localparam logic [ADDR_W-1:0] REG_ENABLES   = 3'b101;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: N-stage synchronizer with reset level and registered level/rise/fall outputs
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic r_q, r_rise, r_fall;
  always_ff @(posedge clk)
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_q    <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_q    <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_q;
      r_fall <= ~r_sync[STAGES-1] & r_q;
    end
  // level is delayed with the edge flags so mosi lines up with the sck rise event
  assign o_level = r_q;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

// File: rtl/serial_reg_loader.sv
// serial_reg_loader: turns 8-bit serial frames (addr[7:5], data[4:0]) into register-write strobes
module serial_reg_loader
  import tonegen_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              cs_n_i,
  output logic              write_strobe_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] data_o,
  output logic              frame_err_o,
  output logic              busy_o
);
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .i_async(sck_i),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .i_async(cs_n_i),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .i_async(mosi_i),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  assign w_unused = &{w_sck_lvl, w_sck_fall, w_mosi_rise, w_mosi_fall};
  state_t                r_state, w_state_nxt;
  logic [2:0]            r_cnt;
  logic [FRAME_BITS-1:0] r_sr, w_sr_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_stb, r_err;
  logic                  w_shift, w_done;
  // a cs_n rise in the same cycle as an sck rise drops that bit
  assign w_shift  = w_sck_rise & ~w_cs_rise & (r_state != IDLE);
  assign w_sr_nxt = {r_sr[FRAME_BITS-2:0], w_mosi};
  assign w_done   = w_shift & (r_state == SHIFT) & (r_cnt == 3'd7);
  always_comb
    w_state_nxt = (r_state == IDLE)  ? (w_cs_fall ? SHIFT : IDLE) :
                  (r_state == SHIFT) ? (w_cs_rise ? IDLE : w_done ? COMMIT : SHIFT) :
                  (w_cs_lvl ? IDLE : SHIFT);
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stb   <= w_done;
      r_err   <= (r_state == SHIFT) && w_cs_rise && (r_cnt != 3'd0);
      if (r_state == IDLE && w_cs_fall) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sr  <= w_sr_nxt;
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_done) begin
        r_addr <= w_sr_nxt[FRAME_BITS-1 -: ADDR_W];
        r_data <= w_sr_nxt[DATA_W-1:0];
      end
    end
  assign write_strobe_o = r_stb;
  assign address_o      = r_addr;
  assign data_o         = r_data;
  assign frame_err_o    = r_err;
  assign busy_o         = (r_state == SHIFT);
endmodule
